// File: rtl/spi_frame_tx.sv
// ============================================================================
// Module   : spi_frame_tx
// Brief    : Mode-0 SPI master sending one header(+payload) packet per request.
//            Optional XOR checksum byte enabled by `define SPI_FRAME_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_frame_tx #(
  parameter int CLK_DIV       = 5,
  parameter int PAYLOAD_BYTES = 4,
  parameter int GAP_SCLKS     = 2,
  parameter int GUARD_SCLKS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cmd,
  input  logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       ready,
  output logic                       done,
  output logic                       sclk,
  output logic                       mosi,
  output logic                       cs_n
);

`ifdef SPI_FRAME_CHECKSUM_EN
  localparam int c_DATA_BYTES = PAYLOAD_BYTES + 1;
`else
  localparam int c_DATA_BYTES = PAYLOAD_BYTES;
`endif
  localparam int c_SR_W = 8 * (1 + c_DATA_BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_TAIL  = 3'd4,
    S_GUARD = 3'd5
  } state_t;

  state_t            r_state;
  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  logic [7:0]        r_div;
  logic              w_tick;
  logic [c_SR_W-1:0] r_sh;
  logic [c_SR_W-1:0] w_load;
  logic              r_cmd;
  logic [2:0]        r_bit;
  logic [4:0]        r_byte;
  logic [15:0]       r_cnt;

  // Reset asserts asynchronously but releases only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_tick = (r_div == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_div <= 8'd0;
    end else if (r_state == S_IDLE || w_tick) begin
      r_div <= 8'd0;
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

  // Transmit image: header in the top byte, payload byte 0 right below it.
  assign w_load[c_SR_W-1 -: 8] = {7'd0, cmd};

  for (genvar g = 0; g < PAYLOAD_BYTES; g++) begin : g_pack
    assign w_load[c_SR_W-9-8*g -: 8] = payload[8*g +: 8];
  end

`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0] w_csum;

  always_comb begin
    w_csum = 8'h00;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      w_csum = w_csum ^ payload[8*i +: 8];
    end
  end

  assign w_load[7:0] = w_csum;
`endif

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_GUARD;
      r_sh    <= '0;
      r_cmd   <= 1'b0;
      r_bit   <= 3'd0;
      r_byte  <= 5'd0;
      r_cnt   <= 16'd0;
      ready   <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sh    <= w_load;
            r_cmd   <= cmd;
            r_bit   <= 3'd0;
            r_byte  <= 5'd0;
            r_cnt   <= 16'd0;
            mosi    <= w_load[c_SR_W-1];
            cs_n    <= 1'b0;
            ready   <= 1'b0;
            r_state <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (w_tick) begin
            sclk    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (w_tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              r_sh <= r_sh << 1;
              mosi <= r_sh[c_SR_W-2];
              if (r_bit != 3'd7) begin
                r_bit <= r_bit + 3'd1;
              end else begin
                r_bit  <= 3'd0;
                r_byte <= r_byte + 5'd1;
                r_cnt  <= 16'd0;
                if (r_byte == 5'd0) begin
                  if (r_cmd) begin
                    r_state <= S_GAP;
                  end else begin
                    mosi    <= 1'b0;
                    r_state <= S_TAIL;
                  end
                end else if (r_byte == 5'(c_DATA_BYTES)) begin
                  mosi    <= 1'b0;
                  r_state <= S_TAIL;
                end
              end
            end
          end
        end

        // sclk stays low; the next SHIFT tick is the first payload rising edge.
        S_GAP: begin
          if (w_tick) begin
            if (r_cnt == 16'(2*GAP_SCLKS - 1)) begin
              r_cnt   <= 16'd0;
              r_state <= S_SHIFT;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end

        S_TAIL: begin
          if (w_tick) begin
            if (r_cnt == 16'd1) begin
              r_cnt   <= 16'd0;
              cs_n    <= 1'b1;
              done    <= 1'b1;
              r_state <= S_GUARD;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end

        S_GUARD: begin
          if (w_tick) begin
            if (r_cnt == 16'(2*GUARD_SCLKS - 1)) begin
              r_cnt   <= 16'd0;
              ready   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end

        default: begin
          cs_n    <= 1'b1;
          sclk    <= 1'b0;
          mosi    <= 1'b0;
          r_state <= S_GUARD;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_tx.sv
// ============================================================================
// Module   : tb_spi_frame_tx
// Brief    : Randomized self-checking bench for spi_frame_tx against a packet model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_frame_tx;

  localparam int CLK_DIV       = 5;
  localparam int PAYLOAD_BYTES = 4;
  localparam int GAP_SCLKS     = 2;
  localparam int GUARD_SCLKS   = 1;
  localparam int PW            = 8 * PAYLOAD_BYTES;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          cmd     = 1'b0;
  logic [PW-1:0] payload = '0;
  logic          ready;
  logic          done;
  logic          sclk;
  logic          mosi;
  logic          cs_n;

  int total = 0;
  int bad   = 0;

  spi_frame_tx #(
    .CLK_DIV      (CLK_DIV),
    .PAYLOAD_BYTES(PAYLOAD_BYTES),
    .GAP_SCLKS    (GAP_SCLKS),
    .GUARD_SCLKS  (GUARD_SCLKS)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmd    (cmd),
    .payload(payload),
    .ready  (ready),
    .done   (done),
    .sclk   (sclk),
    .mosi   (mosi),
    .cs_n   (cs_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Line monitor: collects sampled bits, rise times and done pulses.
  int   cyc          = 0;
  int   last_mosi_ch = 0;
  int   last_cs_rise = -1;
  int   done_cnt     = 0;
  logic p_sclk       = 1'b0;
  logic p_mosi       = 1'b0;
  logic p_cs         = 1'b1;
  bit   rx_bits[$];
  int   rise_t[$];

  always @(negedge clk) begin
    cyc++;
    if (mosi !== p_mosi) last_mosi_ch = cyc;
    if (sclk === 1'b1 && p_sclk === 1'b0) begin
      check("rise_cs_low", cs_n, 0);
      check("mosi_setup", (cyc - last_mosi_ch) >= CLK_DIV, 1);
      rx_bits.push_back(mosi);
      rise_t.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("done_cs_high", cs_n, 1);
    end
    if (cs_n === 1'b1 && p_cs === 1'b0) last_cs_rise = cyc;
    if (cs_n === 1'b0 && p_cs === 1'b1 && last_cs_rise >= 0)
      check("cs_guard", (cyc - last_cs_rise) >= 2*CLK_DIV, 1);
    p_sclk = sclk;
    p_mosi = mosi;
    p_cs   = cs_n;
  end

  function automatic logic [PW-1:0] rand_payload();
    logic [PW-1:0] p;
    for (int i = 0; i < PAYLOAD_BYTES; i++) p[8*i +: 8] = 8'($urandom_range(0, 255));
    return p;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    check({tag, "_ready"}, ready, 1);
  endtask

  task automatic send(input logic c, input logic [PW-1:0] p, input string tag, input bit poke);
    logic [7:0] exp_b[$];
    logic [7:0] b;
    int n, d0, t_done, rs, dc;
`ifdef SPI_FRAME_CHECKSUM_EN
    logic [7:0] x;
`endif
    // Reference packet: header = cmd, then payload bytes in order (+ XOR byte).
    exp_b.push_back({7'd0, c});
    if (c) begin
      for (int i = 0; i < PAYLOAD_BYTES; i++) exp_b.push_back(p[8*i +: 8]);
`ifdef SPI_FRAME_CHECKSUM_EN
      x = 8'h00;
      for (int i = 0; i < PAYLOAD_BYTES; i++) x = x ^ p[8*i +: 8];
      exp_b.push_back(x);
`endif
    end

    wait_ready(tag);
    rx_bits.delete();
    rise_t.delete();
    d0      = done_cnt;
    start   = 1'b1;
    cmd     = c;
    payload = p;
    step();
    start   = 1'b0;
    cmd     = ~c;
    payload = rand_payload();
    check({tag, "_ready_drop"}, ready, 0);
    check({tag, "_setup_cs"}, cs_n, 0);
    check({tag, "_setup_sclk"}, sclk, 0);

    if (poke) begin
      repeat (30) step();
      start = 1'b1;
      cmd   = 1'b0;
      step();
      start = 1'b0;
    end

    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      step();
      n++;
    end
    check({tag, "_done"}, done_cnt - d0, 1);
    t_done = cyc;
    wait_ready(tag);
    check({tag, "_guard_len"}, cyc - t_done, 2*GUARD_SCLKS*CLK_DIV);

    check({tag, "_rises"}, rise_t.size(), 8*exp_b.size());
    for (int k = 0; k < exp_b.size(); k++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++)
        if (8*k + j < rx_bits.size()) b = {b[6:0], rx_bits[8*k + j]};
      check($sformatf("%s_byte%0d", tag, k), b, exp_b[k]);
    end
    for (int i = 1; i < rise_t.size(); i++) begin
      if (i % 8 != 0)
        check($sformatf("%s_period%0d", tag, i), rise_t[i] - rise_t[i-1], 2*CLK_DIV);
      else if (i == 8)
        check({tag, "_hdr_gap"}, (rise_t[8] - rise_t[7]) >= (2*GAP_SCLKS + 2)*CLK_DIV, 1);
    end

    if (poke) begin
      rs = rise_t.size();
      dc = done_cnt;
      repeat (40) step();
      check({tag, "_no_extra_rise"}, rise_t.size(), rs);
      check({tag, "_no_extra_done"}, done_cnt, dc);
      check({tag, "_idle_cs"}, cs_n, 1);
    end
  endtask

  task automatic reset_mid();
    int n, d0;
    wait_ready("rstmid");
    rx_bits.delete();
    rise_t.delete();
    d0      = done_cnt;
    start   = 1'b1;
    cmd     = 1'b1;
    payload = rand_payload();
    step();
    start = 1'b0;
    n = 0;
    while (rise_t.size() < 20 && n < 2000) begin
      step();
      n++;
    end
    check("rstmid_reach20", rise_t.size(), 20);
    rst_n = 1'b0;
    #1;
    check("rstmid_cs_n", cs_n, 1);
    check("rstmid_sclk", sclk, 0);
    check("rstmid_ready", ready, 0);
    repeat (4) step();
    rst_n = 1'b1;
    repeat (4) step();
    check("rstmid_no_done", done_cnt, d0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step();
    check("rst_ready_held", ready, 0);

    send(1'b0, rand_payload(), "init", 1'b0);
    send(1'b1, 32'h0F0F_0005, "frame", 1'b0);
    send(1'b1, 32'h0804_0201, "csum", 1'b0);
    send(1'b1, rand_payload(), "busy", 1'b1);
    for (int i = 0; i < 6; i++)
      send(1'($urandom_range(0, 1)), rand_payload(), $sformatf("rand%0d", i), 1'b0);
    reset_mid();
    send(1'b0, rand_payload(), "post_rst", 1'b0);
    send(1'b1, rand_payload(), "post_rst_frame", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
